// File: rtl/rf_fifo_pkg.sv
// Shared sizing, types and occupancy helpers for the 16x65 register-file FIFO controller.
package rf_fifo_pkg;

  localparam int RF_DEPTH   = 16;
  localparam int RF_WIDTH   = 65;
  localparam int RF_AW      = 4;
  localparam int RF_CW      = 5;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = 2;

  typedef logic [RF_WIDTH-1:0] data_t;
  typedef logic [RF_AW-1:0]    addr_t;
  typedef logic [RF_CW-1:0]    cnt_t;
  typedef logic [OCC_W-1:0]    occ_t;

  // A new read may issue when the data already in or heading for the skid leaves one slot free.
  function automatic logic read_room(input occ_t occ, input logic rd_pend, input logic pop);
    return ({1'b0, occ} + {2'b00, rd_pend}) <= (3'd1 + {2'b00, pop});
  endfunction

  function automatic logic skid_room(input occ_t occ, input logic pop);
    return {1'b0, occ} <= (3'd1 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/rf_fifo_skid.sv
// Two-entry output skid buffer; entry 0 is always the head presented to the consumer.
module rf_fifo_skid
  import rf_fifo_pkg::*;
(
  input  logic  rclk,
  input  logic  rst_l,
  input  logic  wr_en,
  input  data_t wr_data,
  input  logic  pop,
  output occ_t  occ,
  output logic  out_vld,
  output data_t out_data
);

  data_t [SKID_DEPTH-1:0] ent_q;
  data_t [SKID_DEPTH-1:0] ent_d;
  data_t [SKID_DEPTH-1:0] shift_src;
  occ_t                   occ_q;
  occ_t                   occ_d;
  occ_t                   wr_idx;
  logic                   vld_q;
  logic                   pop_ok;

  assign pop_ok = pop & (occ_q != '0);
  // Arrivals land behind whatever survives this cycle's pop, so pop+write never bubbles.
  assign wr_idx = occ_q - occ_t'(pop_ok);

  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_src
    if (gi + 1 < SKID_DEPTH) begin : g_next
      assign shift_src[gi] = ent_q[gi+1];
    end else begin : g_tail
      assign shift_src[gi] = ent_q[gi];
    end
  end

  always_comb begin
    occ_d = occ_q + occ_t'(wr_en) - occ_t'(pop_ok);
    for (int i = 0; i < SKID_DEPTH; i++) begin
      ent_d[i] = pop_ok ? shift_src[i] : ent_q[i];
      if (wr_en && (wr_idx == occ_t'(i))) begin
        ent_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      ent_q <= '0;
      occ_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
      vld_q <= (occ_d != '0);
    end
  end

  assign occ      = occ_q;
  assign out_vld  = vld_q;
  assign out_data = ent_q[0];

endmodule

// File: rtl/rf_fifo_ctl_16x65.sv
// FIFO controller around the 16x65 two-port register file with a 2-entry output skid.
// Define RF_FIFO_BYPASS_EN to let pushes into an empty FIFO skip the array (1-cycle latency).
module rf_fifo_ctl_16x65
  import rf_fifo_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             rclk,
  input  logic             rst_l,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic             rf_wr_csn,
  output logic [RF_AW-1:0] rf_wr_a,
  output logic [WIDTH-1:0] rf_di,
  output logic             rf_rd_csn,
  output logic [RF_AW-1:0] rf_rd_a,
  input  logic [WIDTH-1:0] rf_do,
  output logic [RF_CW-1:0] count
);

  localparam cnt_t FULL = cnt_t'(DEPTH);

  addr_t wptr_q, wptr_d;
  addr_t rptr_q, rptr_d;
  cnt_t  count_q, count_d;
  logic  rd_pend_q, rd_pend_d;
  logic  in_rdy_q, in_rdy_d;

  occ_t  occ;
  logic  skid_vld;
  data_t skid_data;
  logic  pop;
  logic  push;
  logic  byp;
  logic  arr_push;
  logic  issue;
  logic  skid_wr;
  data_t skid_wdata;

  assign pop  = skid_vld & out_rdy;
  // Gating with rst_l keeps both array strobes idle in the very first reset cycle.
  assign push = rst_l & in_vld & in_rdy_q;

`ifdef RF_FIFO_BYPASS_EN
  assign byp        = push & (count_q == '0) & ~rd_pend_q & skid_room(occ, pop);
  assign skid_wdata = byp ? in_data : rf_do;
`else
  assign byp        = 1'b0;
  assign skid_wdata = rf_do;
`endif

  assign arr_push = push & ~byp;
  assign issue    = rst_l & (count_q != '0) & read_room(occ, rd_pend_q, pop);
  assign skid_wr  = rd_pend_q | byp;

  always_comb begin
    wptr_d    = wptr_q + addr_t'(arr_push);
    rptr_d    = rptr_q + addr_t'(issue);
    count_d   = count_q + cnt_t'(arr_push) - cnt_t'(issue);
    rd_pend_d = issue;
    in_rdy_d  = (count_d != FULL);
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      in_rdy_q  <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      in_rdy_q  <= in_rdy_d;
    end
  end

  rf_fifo_skid u_skid (
    .rclk     (rclk),
    .rst_l    (rst_l),
    .wr_en    (skid_wr),
    .wr_data  (skid_wdata),
    .pop      (pop),
    .occ      (occ),
    .out_vld  (skid_vld),
    .out_data (skid_data)
  );

  assign in_rdy    = in_rdy_q;
  assign out_vld   = skid_vld;
  assign out_data  = skid_data;
  assign rf_wr_csn = ~arr_push;
  assign rf_wr_a   = wptr_q;
  assign rf_di     = in_data;
  assign rf_rd_csn = ~issue;
  assign rf_rd_a   = rptr_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rf_fifo_ctl_16x65.sv
// Scoreboard bench for rf_fifo_ctl_16x65 with a behavioural 16x65 register-file model.
module tb_rf_fifo_ctl_16x65;

`ifdef RF_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic        rclk = 1'b0;
  logic        rst_l;
  logic        in_vld;
  logic [64:0] in_data;
  logic        in_rdy;
  logic        out_vld;
  logic [64:0] out_data;
  logic        out_rdy;
  logic        rf_wr_csn;
  logic [3:0]  rf_wr_a;
  logic [64:0] rf_di;
  logic        rf_rd_csn;
  logic [3:0]  rf_rd_a;
  logic [64:0] rf_do = '0;
  logic [4:0]  count;

  logic [64:0] mem [16];
  logic [64:0] sb [$];
  int n_chk = 0;
  int n_err = 0;
  int pop_cnt = 0;

  always #5 rclk = ~rclk;

  rf_fifo_ctl_16x65 dut (
    .rclk      (rclk),
    .rst_l     (rst_l),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_rdy    (in_rdy),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .rf_wr_csn (rf_wr_csn),
    .rf_wr_a   (rf_wr_a),
    .rf_di     (rf_di),
    .rf_rd_csn (rf_rd_csn),
    .rf_rd_a   (rf_rd_a),
    .rf_do     (rf_do),
    .count     (count)
  );

  // Register-file model: synchronous write, read data valid the cycle after the read strobe.
  always @(posedge rclk) begin
    if (!rf_wr_csn) mem[rf_wr_a] <= rf_di;
    if (!rf_rd_csn) rf_do <= mem[rf_rd_a];
  end

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge rclk) begin
    if (!rst_l) begin
      sb.delete();
    end else begin
      if (out_vld && out_rdy) begin
        logic [64:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : ~out_data;
        chk("out_data", out_data, exp);
        pop_cnt++;
        $display("pop %0d data=%h", pop_cnt, out_data);
      end
      if (in_vld && in_rdy) sb.push_back(in_data);
      chk("cnt_le16", 65'(count <= 5'd16), 65'd1);
      if (!rf_wr_csn && !rf_rd_csn) chk("rw_same_addr", 65'(rf_wr_a == rf_rd_a), 65'd0);
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int pushed;
    int cyc;
    int pops0;
    logic acc;

    rst_l = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    repeat (3) tick();
    @(negedge rclk);
    chk("rst_out_vld", 65'(out_vld), 65'd0);
    chk("rst_count", 65'(count), 65'd0);
    chk("rst_in_rdy", 65'(in_rdy), 65'd0);
    chk("rst_wr_csn", 65'(rf_wr_csn), 65'd1);
    chk("rst_rd_csn", 65'(rf_rd_csn), 65'd1);
    tick(); rst_l = 1'b1;
    @(negedge rclk); chk("rel_in_rdy0", 65'(in_rdy), 65'd0);
    tick();
    @(negedge rclk); chk("rel_in_rdy1", 65'(in_rdy), 65'd1);

    // Single push
    tick(); in_vld = 1'b1; in_data = 65'h1_0000_0000_DEAD_BEEF; out_rdy = 1'b1;
    @(negedge rclk);
`ifdef RF_FIFO_BYPASS_EN
    chk("p1_wr_csn", 65'(rf_wr_csn), 65'd1);
    tick(); in_vld = 1'b0;
    @(negedge rclk);
    chk("p1_out_vld", 65'(out_vld), 65'd1);
    chk("p1_out_data", out_data, 65'h1_0000_0000_DEAD_BEEF);
    chk("p1_count", 65'(count), 65'd0);
`else
    chk("p1_wr_csn", 65'(rf_wr_csn), 65'd0);
    chk("p1_wr_a", 65'(rf_wr_a), 65'd0);
    tick(); in_vld = 1'b0;
    @(negedge rclk);
    chk("p1_rd_csn", 65'(rf_rd_csn), 65'd0);
    chk("p1_rd_a", 65'(rf_rd_a), 65'd0);
    chk("p1_count", 65'(count), 65'd1);
    chk("p1_vld_n1", 65'(out_vld), 65'd0);
    tick();
    @(negedge rclk); chk("p1_vld_n2", 65'(out_vld), 65'd0);
    tick();
    @(negedge rclk);
    chk("p1_out_vld", 65'(out_vld), 65'd1);
    chk("p1_out_data", out_data, 65'h1_0000_0000_DEAD_BEEF);
`endif
    tick();
    @(negedge rclk); chk("p1_count_end", 65'(count), 65'd0);

    // Fill with the consumer stalled
    tick(); out_rdy = 1'b0; idx = 0; in_vld = 1'b1; in_data = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk); acc = in_vld && in_rdy;
      tick();
      if (acc) idx++;
      in_data = 65'(idx);
    end
    @(negedge rclk);
    chk("fill_accepted", 65'(idx), 65'd18);
    chk("fill_count", 65'(count), 65'd16);
    chk("fill_in_rdy", 65'(in_rdy), 65'd0);
    chk("fill_out_vld", 65'(out_vld), 65'd1);
    tick(); in_vld = 1'b0; out_rdy = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge rclk); chk("drain_gap", 65'(out_vld), 65'd1);
      tick();
    end
    @(negedge rclk);
    chk("drain_done_vld", 65'(out_vld), 65'd0);
    chk("drain_sb", 65'(sb.size()), 65'd0);

    // Streaming
    tick(); in_vld = 1'b1; out_rdy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_data = 65'(1000 + k);
      @(negedge rclk);
      chk("stream_rdy", 65'(in_rdy), 65'd1);
      if (k >= LAT) chk("stream_vld", 65'(out_vld), 65'd1);
      tick();
    end
    in_vld = 1'b0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin tick(); cyc++; end
    chk("stream_drain", 65'(sb.size()), 65'd0);

    // Random traffic
    pushed = 0; cyc = 0; pops0 = pop_cnt;
    while (pushed < 1000 && cyc < 20000) begin
      @(negedge rclk); acc = in_vld && in_rdy;
      tick(); cyc++;
      if (acc) pushed++;
      if (acc || !in_vld) begin
        in_vld  = ($urandom_range(0, 3) != 0) && (pushed < 1000);
        in_data = {1'($urandom_range(0, 1)), $urandom(), $urandom()};
      end
      out_rdy = 1'($urandom_range(0, 1));
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    chk("rand_pushed", 65'(pushed), 65'd1000);
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin tick(); cyc++; end
    chk("rand_drain", 65'(sb.size()), 65'd0);
    chk("rand_pops", 65'(pop_cnt - pops0), 65'd1000);

    // Reset with count=7 and a read in flight
    tick(); out_rdy = 1'b0; in_vld = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_data = 65'(500 + k);
      tick();
    end
    in_vld = 1'b0;
    repeat (5) tick();
    @(negedge rclk);
    chk("pre_count", 65'(count), 65'd7);
    tick(); in_vld = 1'b1; in_data = 65'd509; out_rdy = 1'b1;
    @(negedge rclk);
    chk("pre_rd_issue", 65'(rf_rd_csn), 65'd0);
    tick(); in_vld = 1'b0; out_rdy = 1'b0; rst_l = 1'b0;
    @(negedge rclk); chk("pre_rst_count", 65'(count), 65'd7);
    tick(); rst_l = 1'b1;
    @(negedge rclk);
    chk("mid_out_vld", 65'(out_vld), 65'd0);
    chk("mid_count", 65'(count), 65'd0);
    chk("mid_in_rdy", 65'(in_rdy), 65'd0);
    tick();
    @(negedge rclk); chk("mid_in_rdy1", 65'(in_rdy), 65'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge rclk); chk("mid_stale", 65'(out_vld), 65'd0);
    end
    tick(); in_vld = 1'b1; in_data = 65'd777; out_rdy = 1'b1;
    tick(); in_vld = 1'b0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin tick(); cyc++; end
    chk("post_rst_drain", 65'(sb.size()), 65'd0);
    @(negedge rclk); chk("post_rst_count", 65'(count), 65'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_fifo_ctl_16x65.md
# rf_fifo_ctl_16x65

Synchronous FIFO controller wrapped around the 16-entry x 65-bit two-port register-file array. It turns a valid/ready producer stream into array write/read strobes and presents the array output through a 2-entry output skid stage to a valid/ready consumer. It sits directly in front of and behind the array: it drives the array's write and read ports and consumes its data output.

## Interface
Parameters:
- DEPTH, 16, array entries; fixed, must equal the array depth.
- WIDTH, 65, data width; fixed, must equal the array width.

Ports:
- rclk  in  1  core clock; also drives both array clocks.
- rst_l  in  1  reset, synchronous, active-low.
- in_vld  in  1  producer data valid.
- in_data  in  65  producer data.
- in_rdy  out  1  space available in the FIFO; registered.
- out_vld  out  1  head entry valid; registered.
- out_data  out  65  head entry data; registered.
- out_rdy  in  1  consumer accepts the head entry.
- rf_wr_csn  out  1  array write enable, active-low.
- rf_wr_a  out  4  array write address.
- rf_di  out  65  array write data; equals in_data.
- rf_rd_csn  out  1  array read enable, active-low.
- rf_rd_a  out  4  array read address.
- rf_do  in  65  array read data; valid in the cycle after the read is issued.
- count  out  5  array occupancy, 0..16; registered.

## Operation
Push and pop:
- A push occurs when in_vld & in_rdy. The block drives rf_wr_csn=0 and rf_wr_a=wptr in that same cycle. wptr increments mod 16 at the clock edge.
- in_rdy = (count != 16).
- A pop occurs when out_vld & out_rdy.

Read issue:
- Conditions: count != 0 and (occ + rd_pend - pop) <= 1.
  - occ is the output-stage fill level, 0..2.
  - rd_pend is 1 when the previous cycle issued a read.
- On issue: rf_rd_csn=0 and rf_rd_a=rptr. rptr increments mod 16 and rd_pend is set for the next cycle.
- When rd_pend=1, rf_do is written into the output stage that cycle.

count update, computed at each edge:
- count + push - issue.
- A push and an issue in the same cycle leave count unchanged.

Output stage:
- 2-entry skid buffer. out_data is always the head entry.
- A simultaneous pop and arrival shift the buffer and append; there is no bubble.

Address conflicts:
- The array never sees a read and a write to the same address in the same cycle.
- rptr==wptr only when count is 0 (no issue) or 16 (no push). The verifier must assert this.

Reset behaviour:
- While rst_l=0, at each edge: wptr=rptr=0, count=0, occ=0, rd_pend=0, out_vld=0, out_data=0, in_rdy=0. Both csn outputs are forced to 1.
- in_rdy rises in the first cycle after rst_l returns high.
- A reset during operation discards all contents, including an in-flight read. rf_do arriving in the cycle after reset is ignored.

Other rules:
- No error outputs. Overflow and underflow are impossible by construction.
- Pushes made while in_rdy=0 are ignored.

## Timing
- Push in cycle N (non-bypass path):
  - Array write occurs in the low phase of N.
  - count reflects the entry at N+1.
  - Read issued in N+1, rf_do valid in N+2, out_vld=1 in N+3.
- Sustained throughput: one push and one pop per cycle with out_rdy held high.
- Occupancy:
  - Up to 16 entries in the array plus 2 in the output stage; maximum 18 entries outstanding.
  - in_rdy tracks array occupancy only.
- in_rdy falls in the cycle after the 16th unmatched push.

## Configuration
- Macro: RF_FIFO_BYPASS_EN.
- Defined: when count==0, rd_pend==0 and occ - pop <= 1, a push is written directly into the output stage. There is no array write. Latency is push in N, out_vld in N+1.
- Undefined: every push goes through the array, with a minimum latency of 3 cycles.
- Ordering is preserved in both builds.

## Structure
- Shared package rf_fifo_pkg holds:
  - RF_DEPTH=16, RF_WIDTH=65, RF_AW=4
  - the count width (5)
  - the output-stage depth (2)
- One sub-module: rf_fifo_skid. It is the 2-entry output buffer and takes wr_en, wr_data, pop, and outputs occ, out_vld, out_data.
- Pointer, count and read-issue logic live in the top.

## Test plan
- Reset, then single push of 65'h1_0000_0000_DEAD_BEEF with out_rdy=1:
  - rf_wr_a=0, rf_rd_a=0 one cycle later.
  - out_data=65'h1_0000_0000_DEAD_BEEF at N+3 (N+1 with RF_FIFO_BYPASS_EN).
  - count returns to 0.
- Fill, out_rdy=0, push 0..19:
  - in_rdy drops after 18 accepted values (2 in the output stage, count=16).
  - Values 18 and 19 are held by the producer.
  - Then out_rdy=1 drains 0..17 in order with no gaps.
- Streaming: continuous in_vld and out_rdy for 100 cycles with incrementing data.
  - One output per cycle after the initial latency.
  - Pointers wrap 15->0 with no rptr==wptr read/write overlap.
- Random out_rdy (50%) with 1000 random pushes: the output sequence equals the input sequence and count never exceeds 16.
- Mid-stream reset with count=7 and a read pending:
  - Next cycle out_vld=0, count=0, in_rdy=0.
  - in_rdy=1 one cycle after release.
  - Stale rf_do does not appear on the output.
